memory_copy_engine: RTL and testbench
=====================================

Name: memory_copy_engine

Overview:
- Bus initiator that drives the single-port RAM's `address`, `data_in` and `write` inputs and reads its asynchronous `data_out`.
- Performs block copy (src→dst) or block fill (constant→dst) on request, then returns to idle.
- Sits between the RISC control unit and the data memory; memory access muxing is external.

Parameters:
- DATAWIDTH, 8, width of data word and of address bus.
- LENWIDTH, 8, width of the transfer-length input. Maximum transfer is 2^LENWIDTH-1 words.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- mode  input  1  0 = copy, 1 = fill.
- src_addr  input  DATAWIDTH  copy source base; ignored in fill mode.
- dst_addr  input  DATAWIDTH  destination base.
- length  input  LENWIDTH  number of words to transfer.
- fill_value  input  DATAWIDTH  word written in fill mode.
- mem_address  output  DATAWIDTH  drives the RAM address.
- mem_wdata  output  DATAWIDTH  drives the RAM data_in.
- mem_write  output  1  drives the RAM write.
- mem_rdata  input  DATAWIDTH  from the RAM data_out; combinational read.
- busy  output  1  high in READ and WRITE states.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (synchronous, active-high) forces IDLE, all pointers and counters to 0, and every output to 0.
- States:
  - IDLE: outputs 0. On `start`=1, capture src_addr, dst_addr, length, mode and fill_value into internal registers.
    - length=0 → DONE.
    - mode=0 → READ.
    - mode=1 → WRITE.
  - READ: mem_address=src_ptr, mem_write=0, busy=1. At the clock edge, mem_rdata is latched into hold_reg and src_ptr increments; next state is WRITE.
  - WRITE: mem_address=dst_ptr, mem_wdata=hold_reg (copy) or fill_reg (fill), mem_write=1, busy=1. At the clock edge, dst_ptr increments and remaining decrements.
    - remaining reaches 0 → DONE.
    - otherwise copy → READ, fill → WRITE.
  - DONE: done=1, busy=0, mem_write=0 for exactly one cycle, then IDLE.
- Latency, counted in cycles after the start-sampling edge:
  - copy of N words: 2N busy cycles, then done.
  - fill of N words: N busy cycles, then done.
  - length=0: done in the first cycle.
- Pointers are DATAWIDTH bits and wrap modulo 2^DATAWIDTH (0xFF+1 → 0x00). No error is raised on wrap.
- Input registers are loaded only at start acceptance. Input changes while busy have no effect.
- start while busy or in DONE is ignored; it is not queued.
- Overlapping regions are copied strictly forward, word by word. When dst > src and the regions overlap, already-written source words are re-read. This is the defined behaviour.
- mem_wdata is 0 outside WRITE. mem_address is 0 in IDLE and DONE.
- Reset mid-transfer: at that edge mem_write deasserts and the FSM returns to IDLE with no done pulse. Words already written remain in memory.

Decomposition:
- Shared package holds:
  - state encodings (IDLE, READ, WRITE, DONE);
  - MODE_COPY and MODE_FILL constants.
- No sub-module: FSM, two pointers, remaining counter and hold register stay in one module.
- Bench instantiates the existing RAM as the responder.

Test Plan:
- Copy: preload mem[0x10..0x12]={0xA1,0xB2,0xC3}; start mode=0, src=0x10, dst=0x20, len=3 → busy for 6 cycles, done pulse in the 7th cycle, mem[0x20..0x22]={0xA1,0xB2,0xC3}, mem[0x10..0x12] unchanged.
- Fill: mode=1, dst=0x40, len=4, fill_value=0x5A → mem_write high for 4 consecutive cycles, mem[0x40..0x43]=0x5A, mem[0x44] untouched, done in the 5th cycle.
- Wrap: fill dst=0xFE, len=4, value=0x77 → writes occur at 0xFE, 0xFF, 0x00, 0x01 in that order.
- Zero length: start with len=0 → busy never asserts, mem_write never asserts, done=1 in the first cycle after start.
- Reset mid-op: copy len=8 from 0x00 to 0x80; assert reset in the 5th busy cycle → mem_write=0 from that edge, outputs 0, no done pulse, only mem[0x80..0x81] modified.
- Start while busy: second start pulse during a copy (changing src_addr) → ignored, first transfer completes unaltered, exactly one done pulse.

Source files
------------

// File: rtl/memory_copy_engine_pkg.sv
// Shared definitions for the memory copy engine.
//   state_e   : FSM state encoding (idle, read, write, done)
//   MODE_COPY : mode input value selecting block copy (src -> dst)
//   MODE_FILL : mode input value selecting block fill (constant -> dst)
package memory_copy_engine_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRead  = 2'd1,
    StWrite = 2'd2,
    StDone  = 2'd3
  } state_e;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/memory_copy_engine.sv
// Block copy / block fill bus initiator for a single-port RAM with combinational read.
// Ports:
//   clk, reset      : rising-edge clock, synchronous active-high reset
//   start, mode     : request (sampled only in idle), 0 = copy, 1 = fill
//   src_addr        : copy source base (ignored in fill mode)
//   dst_addr        : destination base
//   length          : number of words to transfer (0 completes immediately)
//   fill_value      : word written in fill mode
//   mem_address     : RAM address
//   mem_wdata       : RAM write data (0 outside the write state)
//   mem_write       : RAM write enable
//   mem_rdata       : RAM read data, valid in the same cycle as mem_address
//   busy            : high while reading or writing
//   done            : one-cycle completion pulse
module memory_copy_engine
  import memory_copy_engine_pkg::*;
#(
  parameter int unsigned DATAWIDTH = 8,
  parameter int unsigned LENWIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 mode,
  input  logic [DATAWIDTH-1:0] src_addr,
  input  logic [DATAWIDTH-1:0] dst_addr,
  input  logic [LENWIDTH-1:0]  length,
  input  logic [DATAWIDTH-1:0] fill_value,
  output logic [DATAWIDTH-1:0] mem_address,
  output logic [DATAWIDTH-1:0] mem_wdata,
  output logic                 mem_write,
  input  logic [DATAWIDTH-1:0] mem_rdata,
  output logic                 busy,
  output logic                 done
);

  state_e                 state_q, state_d;
  logic [DATAWIDTH-1:0]   src_ptr_q, src_ptr_d;
  logic [DATAWIDTH-1:0]   dst_ptr_q, dst_ptr_d;
  logic [LENWIDTH-1:0]    remaining_q, remaining_d;
  logic [DATAWIDTH-1:0]   hold_q, hold_d;
  logic [DATAWIDTH-1:0]   fill_q, fill_d;
  logic                   mode_q, mode_d;

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      src_ptr_q   <= '0;
      dst_ptr_q   <= '0;
      remaining_q <= '0;
      hold_q      <= '0;
      fill_q      <= '0;
      mode_q      <= MODE_COPY;
    end else begin
      state_q     <= state_d;
      src_ptr_q   <= src_ptr_d;
      dst_ptr_q   <= dst_ptr_d;
      remaining_q <= remaining_d;
      hold_q      <= hold_d;
      fill_q      <= fill_d;
      mode_q      <= mode_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (length == '0) begin
            state_d = StDone;
          end else if (mode == MODE_FILL) begin
            state_d = StWrite;
          end else begin
            state_d = StRead;
          end
        end
      end
      StRead:  state_d = StWrite;
      StWrite: begin
        if (remaining_q == LENWIDTH'(1)) begin
          state_d = StDone;
        end else if (mode_q == MODE_FILL) begin
          state_d = StWrite;
        end else begin
          state_d = StRead;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next values; operands are captured only when a request is accepted.
  always_comb begin
    src_ptr_d   = src_ptr_q;
    dst_ptr_d   = dst_ptr_q;
    remaining_d = remaining_q;
    hold_d      = hold_q;
    fill_d      = fill_q;
    mode_d      = mode_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          src_ptr_d   = src_addr;
          dst_ptr_d   = dst_addr;
          remaining_d = length;
          fill_d      = fill_value;
          mode_d      = mode;
        end
      end
      StRead: begin
        hold_d    = mem_rdata;
        // Pointers wrap naturally at the address width.
        src_ptr_d = src_ptr_q + DATAWIDTH'(1);
      end
      StWrite: begin
        dst_ptr_d   = dst_ptr_q + DATAWIDTH'(1);
        remaining_d = remaining_q - LENWIDTH'(1);
      end
      default: ;
    endcase
  end

  // Outputs are decoded purely from the current state.
  always_comb begin
    mem_address = '0;
    mem_wdata   = '0;
    mem_write   = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    unique case (state_q)
      StRead: begin
        mem_address = src_ptr_q;
        busy        = 1'b1;
      end
      StWrite: begin
        mem_address = dst_ptr_q;
        mem_wdata   = (mode_q == MODE_FILL) ? fill_q : hold_q;
        mem_write   = 1'b1;
        busy        = 1'b1;
      end
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_memory_copy_engine.sv
module tb_memory_copy_engine;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       mode;
  logic [7:0] src_addr;
  logic [7:0] dst_addr;
  logic [7:0] length;
  logic [7:0] fill_value;
  logic [7:0] mem_address;
  logic [7:0] mem_wdata;
  logic       mem_write;
  logic [7:0] mem_rdata;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  memory_copy_engine #(
    .DATAWIDTH(8),
    .LENWIDTH (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .mode       (mode),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .length     (length),
    .fill_value (fill_value),
    .mem_address(mem_address),
    .mem_wdata  (mem_wdata),
    .mem_write  (mem_write),
    .mem_rdata  (mem_rdata),
    .busy       (busy),
    .done       (done)
  );

  // Single-port RAM responder: combinational read, synchronous write.
  logic [7:0] mem [256];
  logic [7:0] wr_log [$];
  assign mem_rdata = mem[mem_address];
  always @(posedge clk) begin
    if (mem_write) begin
      mem[mem_address] <= mem_wdata;
      wr_log.push_back(mem_address);
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Background pattern: mem[i] = i ^ 0x3C.
  task automatic init_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h3C;
    wr_log.delete();
  endtask

  // Issues one request and observes it to completion. Cycle 1 is the cycle after the
  // start-sampling edge. If poke > 0, a conflicting start is driven during cycle poke.
  task automatic run_xfer(input logic m, input logic [7:0] s, input logic [7:0] d,
                          input logic [7:0] l, input logic [7:0] f, input int poke,
                          output int nbusy, output int nwr, output int ndone,
                          output int dcyc);
    nbusy = 0; nwr = 0; ndone = 0; dcyc = -1;
    mode = m; src_addr = s; dst_addr = d; length = l; fill_value = f; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      if (c == poke) begin
        start = 1'b1; src_addr = 8'h50; dst_addr = 8'hC0; mode = ~m; length = 8'd9;
      end else begin
        start = 1'b0;
      end
      if (busy) nbusy++;
      if (mem_write) nwr++;
      if (done) begin
        ndone++;
        if (dcyc < 0) dcyc = c;
      end
      if (dcyc >= 0 && c >= dcyc + 3) break;
      @(posedge clk); #1;
    end
    start = 1'b0;
    if (dcyc < 0) check("timeout_no_done", 1, 0);
  endtask

  typedef struct {
    string      name;
    logic       mode;
    logic [7:0] src;
    logic [7:0] dst;
    logic [7:0] len;
    logic [7:0] fill;
    int         exp_busy;
    int         exp_wr;
    logic [7:0] a0;
    logic [7:0] d0;
    logic [7:0] a1;
    logic [7:0] d1;
  } vec_t;

  vec_t vecs [7];
  int   nbusy, nwr, ndone, dcyc;

  initial begin
    // Expected data is hand-computed against the background pattern i ^ 0x3C.
    vecs[0] = '{"fill4",    1'b1, 8'h00, 8'h40, 8'd4, 8'h5A, 4, 4, 8'h43, 8'h5A, 8'h44, 8'h78};
    vecs[1] = '{"fillwrap", 1'b1, 8'h00, 8'hFE, 8'd4, 8'h77, 4, 4, 8'h01, 8'h77, 8'h02, 8'h3E};
    vecs[2] = '{"zerolen",  1'b0, 8'h10, 8'h30, 8'd0, 8'h99, 0, 0, 8'h30, 8'h0C, 8'h31, 8'h0D};
    vecs[3] = '{"copy2",    1'b0, 8'h50, 8'h60, 8'd2, 8'h00, 4, 2, 8'h61, 8'h6D, 8'h50, 8'h6C};
    vecs[4] = '{"overlap",  1'b0, 8'h70, 8'h71, 8'd3, 8'h00, 6, 3, 8'h73, 8'h4C, 8'h74, 8'h48};
    vecs[5] = '{"fill1",    1'b1, 8'h00, 8'h00, 8'd1, 8'hC3, 1, 1, 8'h00, 8'hC3, 8'h01, 8'h3D};
    vecs[6] = '{"copywrap", 1'b0, 8'hFF, 8'h05, 8'd1, 8'h00, 2, 1, 8'h05, 8'hC3, 8'h06, 8'h3A};

    reset = 1'b1; start = 1'b0; mode = 1'b0;
    src_addr = 8'h00; dst_addr = 8'h00; length = 8'd0; fill_value = 8'h00;
    init_mem();
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_write", mem_write, 0);
    check("rst_addr", mem_address, 0);
    check("rst_wdata", mem_wdata, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 7; v++) begin
      init_mem();
      run_xfer(vecs[v].mode, vecs[v].src, vecs[v].dst, vecs[v].len, vecs[v].fill, 0,
               nbusy, nwr, ndone, dcyc);
      check({vecs[v].name, "_busy"}, nbusy, vecs[v].exp_busy);
      check({vecs[v].name, "_writes"}, nwr, vecs[v].exp_wr);
      check({vecs[v].name, "_ndone"}, ndone, 1);
      check({vecs[v].name, "_donecyc"}, dcyc, vecs[v].exp_busy + 1);
      check({vecs[v].name, "_mem0"}, mem[vecs[v].a0], vecs[v].d0);
      check({vecs[v].name, "_mem1"}, mem[vecs[v].a1], vecs[v].d1);
    end

    // Copy of three preloaded words.
    init_mem();
    mem[8'h10] = 8'hA1; mem[8'h11] = 8'hB2; mem[8'h12] = 8'hC3;
    run_xfer(1'b0, 8'h10, 8'h20, 8'd3, 8'h00, 0, nbusy, nwr, ndone, dcyc);
    check("copy3_busy", nbusy, 6);
    check("copy3_donecyc", dcyc, 7);
    check("copy3_dst0", mem[8'h20], 8'hA1);
    check("copy3_dst1", mem[8'h21], 8'hB2);
    check("copy3_dst2", mem[8'h22], 8'hC3);
    check("copy3_src2", mem[8'h12], 8'hC3);
    check("copy3_dst3", mem[8'h23], 8'h1F);

    // Wrap write order.
    init_mem();
    run_xfer(1'b1, 8'h00, 8'hFE, 8'd4, 8'h77, 0, nbusy, nwr, ndone, dcyc);
    check("wrap_nlog", wr_log.size(), 4);
    if (wr_log.size() == 4) begin
      check("wrap_a0", wr_log[0], 8'hFE);
      check("wrap_a1", wr_log[1], 8'hFF);
      check("wrap_a2", wr_log[2], 8'h00);
      check("wrap_a3", wr_log[3], 8'h01);
    end
    check("wrap_memFF", mem[8'hFF], 8'h77);

    // Start while busy: the poke in cycle 2 must be ignored.
    init_mem();
    run_xfer(1'b0, 8'h10, 8'h90, 8'd3, 8'h00, 2, nbusy, nwr, ndone, dcyc);
    check("sbusy_busy", nbusy, 6);
    check("sbusy_ndone", ndone, 1);
    check("sbusy_mem90", mem[8'h90], 8'h2C);
    check("sbusy_mem92", mem[8'h92], 8'h2E);
    check("sbusy_mem93", mem[8'h93], 8'hAF);
    check("sbusy_memC0", mem[8'hC0], 8'hFC);

    // Reset in the 5th busy cycle of an 8-word copy 0x00 -> 0x80.
    init_mem();
    mode = 1'b0; src_addr = 8'h00; dst_addr = 8'h80; length = 8'd8; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("rmid_busy5", busy, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rmid_write", mem_write, 0);
    check("rmid_busy", busy, 0);
    check("rmid_done", done, 0);
    check("rmid_addr", mem_address, 0);
    reset = 1'b0;
    ndone = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("rmid_nodone", ndone, 0);
    check("rmid_m80", mem[8'h80], 8'h3C);
    check("rmid_m81", mem[8'h81], 8'h3D);
    for (int i = 8'h82; i <= 8'h87; i++) check("rmid_untouched", mem[i], i ^ 8'h3C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
